cfg_pass_scheduler: RTL and testbench

- Schedules repeated runs of the pixel-configuration FSM, one run per entry of a host-programmed threshold (umbral) table.
- For each pass: presents the threshold, pulses go, waits for the FSM's done pulse, then waits a programmable settle interval.
- Guards each pass with a chip-write-ready watchdog and supports host abort.
- Sits between the host/register interface and the configuration FSM; o_cfg_abort is OR'd with rst at the FSM reset input.

---
 rtl/cfg_pass_scheduler_pkg.sv | 24 ++
 rtl/cfg_pass_scheduler_umbral_table.sv | 36 +++
 rtl/cfg_pass_scheduler.sv | 172 +++++++++++++++++
 tb/tb_cfg_pass_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pass_scheduler_pkg.sv
// Shared state encoding and helpers for the configuration pass scheduler.
package cfg_pass_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GO     = 3'd2,
    ST_RUN    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !(s inside {ST_IDLE, ST_ERROR, ST_DONE});
  endfunction

  // Watchdog counter width; it only ever has to hold 0..cycles-1.
  function automatic int unsigned wdt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cfg_pass_scheduler_umbral_table.sv
// Host-programmed threshold table: synchronous write, combinational read, async clear.
module cfg_pass_scheduler_umbral_table #(
  parameter int unsigned NB_DATA   = 12,
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned NB_IDX    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic [NB_IDX-1:0]  waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic [NB_IDX-1:0]  raddr_i,
  output logic [NB_DATA-1:0] rdata_o
);

  logic [NB_DATA-1:0] mem_q [N_ENTRIES];

  // Address decode by entry, so out-of-range addresses match nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) mem_q[i] <= '0;
    end else if (wr_i) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        if (waddr_i == NB_IDX'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      if (raddr_i == NB_IDX'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/cfg_pass_scheduler.sv
// Runs the pixel-configuration FSM once per threshold-table entry, with settle
// gaps, a write-ready watchdog and host abort.
module cfg_pass_scheduler
  import cfg_pass_scheduler_pkg::*;
#(
  parameter int unsigned NB_DATA    = 12,
  parameter int unsigned N_ENTRIES  = 8,
  parameter int unsigned NB_IDX     = 3,
  parameter int unsigned NB_SETTLE  = 16,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tbl_wr,
  input  logic [NB_IDX-1:0]    i_tbl_addr,
  input  logic [NB_DATA-1:0]   i_tbl_data,
  input  logic [NB_IDX:0]      i_num_passes,
  input  logic [NB_SETTLE-1:0] i_settle,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_cfg_done,
  input  logic                 i_chip_write_ready,
  output logic                 o_cfg_go,
  output logic [NB_DATA-1:0]   o_cfg_umbral,
  output logic                 o_cfg_abort,
  output logic                 o_busy,
  output logic [NB_IDX-1:0]    o_pass_idx,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int unsigned NB_CNT = NB_IDX + 1;
  localparam int unsigned NB_WDT = wdt_width(WDT_CYCLES);

  state_e               state_q, state_d;
  logic [NB_IDX-1:0]    idx_q, idx_d;
  logic [NB_CNT-1:0]    num_q, num_d, num_req;
  logic [NB_SETTLE-1:0] settle_q, settle_d, scnt_q, scnt_d;
  logic [NB_WDT-1:0]    wdt_q, wdt_d;
  logic [NB_DATA-1:0]   umbral_q, umbral_d, tbl_rdata;
  logic                 error_q, error_d, abort_q, abort_d;
  logic                 go_q, done_q, busy_q;
  logic                 last_pass;

  cfg_pass_scheduler_umbral_table #(
    .NB_DATA   (NB_DATA),
    .N_ENTRIES (N_ENTRIES),
    .NB_IDX    (NB_IDX)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (i_tbl_wr & ~busy_q),
    .waddr_i (i_tbl_addr),
    .wdata_i (i_tbl_data),
    .raddr_i (idx_q),
    .rdata_o (tbl_rdata)
  );

  assign num_req   = (i_num_passes > NB_CNT'(N_ENTRIES)) ? NB_CNT'(N_ENTRIES) : i_num_passes;
  assign last_pass = ((NB_CNT'(idx_q) + NB_CNT'(1)) == num_q);

  // Next-state: abort in a busy state overrides everything else.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    settle_d = settle_q;
    scnt_d   = scnt_q;
    wdt_d    = wdt_q;
    umbral_d = umbral_q;
    error_d  = error_q;
    abort_d  = 1'b0;

    if (is_busy(state_q) && i_abort) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (state_q == ST_ERROR && i_abort) begin
            state_d = ST_IDLE;
          end else if (i_start) begin
            num_d    = num_req;
            settle_d = i_settle;
            idx_d    = '0;
            error_d  = 1'b0;
            state_d  = (num_req == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          umbral_d = tbl_rdata;
          state_d  = ST_GO;
        end
        ST_GO: begin
          wdt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_cfg_done) begin
            scnt_d  = settle_q;
            state_d = (settle_q != '0) ? ST_SETTLE : ST_NEXT;
          end else if (i_chip_write_ready) begin
            wdt_d = '0;
          end else if (wdt_q == NB_WDT'(WDT_CYCLES - 1)) begin
            state_d = ST_ERROR;
          end else begin
            wdt_d = wdt_q + NB_WDT'(1);
          end
        end
        ST_SETTLE: begin
          if (scnt_q == NB_SETTLE'(1)) state_d = ST_NEXT;
          else                         scnt_d  = scnt_q - NB_SETTLE'(1);
        end
        ST_NEXT: begin
          if (last_pass) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + NB_IDX'(1);
            state_d = ST_LOAD;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Watchdog expiry resets the configuration FSM and latches the error.
    if (state_d == ST_ERROR && state_q != ST_ERROR) begin
      abort_d = 1'b1;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      settle_q <= '0;
      scnt_q   <= '0;
      wdt_q    <= '0;
      umbral_q <= '0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      settle_q <= settle_d;
      scnt_q   <= scnt_d;
      wdt_q    <= wdt_d;
      umbral_q <= umbral_d;
      error_q  <= error_d;
      abort_q  <= abort_d;
      go_q     <= (state_d == ST_GO);
      done_q   <= (state_d == ST_DONE);
      busy_q   <= is_busy(state_d);
    end
  end

  assign o_cfg_go     = go_q;
  assign o_cfg_umbral = umbral_q;
  assign o_cfg_abort  = abort_q;
  assign o_busy       = busy_q;
  assign o_pass_idx   = idx_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_cfg_pass_scheduler.sv
// Randomized self-checking bench for cfg_pass_scheduler using a timeline model
// of go/done/settle events derived from pass latencies.
module tb_cfg_pass_scheduler;

  localparam int unsigned NB_DATA   = 12;
  localparam int unsigned N_ENTRIES = 8;
  localparam int unsigned NB_IDX    = 3;
  localparam int unsigned NB_SETTLE = 16;
  localparam int unsigned WDT       = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_tbl_wr;
  logic [NB_IDX-1:0]    i_tbl_addr;
  logic [NB_DATA-1:0]   i_tbl_data;
  logic [NB_IDX:0]      i_num_passes;
  logic [NB_SETTLE-1:0] i_settle;
  logic                 i_start, i_abort, i_cfg_done, i_chip_write_ready;
  logic                 o_cfg_go, o_cfg_abort, o_busy, o_done, o_error;
  logic [NB_DATA-1:0]   o_cfg_umbral;
  logic [NB_IDX-1:0]    o_pass_idx;

  cfg_pass_scheduler #(
    .NB_DATA(NB_DATA), .N_ENTRIES(N_ENTRIES), .NB_IDX(NB_IDX),
    .NB_SETTLE(NB_SETTLE), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_tbl_wr(i_tbl_wr), .i_tbl_addr(i_tbl_addr), .i_tbl_data(i_tbl_data),
    .i_num_passes(i_num_passes), .i_settle(i_settle),
    .i_start(i_start), .i_abort(i_abort), .i_cfg_done(i_cfg_done),
    .i_chip_write_ready(i_chip_write_ready),
    .o_cfg_go(o_cfg_go), .o_cfg_umbral(o_cfg_umbral), .o_cfg_abort(o_cfg_abort),
    .o_busy(o_busy), .o_pass_idx(o_pass_idx), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [NB_DATA-1:0] tbl [N_ENTRIES];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    i_tbl_wr = 0; i_tbl_addr = '0; i_tbl_data = '0; i_num_passes = '0; i_settle = '0;
    i_start = 0; i_abort = 0; i_cfg_done = 0; i_chip_write_ready = 0;
  endtask

  task automatic write_tbl(input int addr, input int data);
    i_tbl_wr = 1; i_tbl_addr = NB_IDX'(addr); i_tbl_data = NB_DATA'(data);
    tbl[addr] = NB_DATA'(data);
    tick();
    i_tbl_wr = 0;
  endtask

  // One scheduled run; abort_pass < 0 means no abort, else abort coincides with that pass's done.
  task automatic run_seq(input int n_req, input int settle, input int abort_pass,
                         input bit noise, input int fixed_lat);
    int p, s, lim, done_c, abort_c;
    int g[8];
    int d[8];
    bit exp_go, in_run, hit_done, exp_busy, exp_done, exp_abort;
    p = (n_req > int'(N_ENTRIES)) ? int'(N_ENTRIES) : n_req;
    i_start = 1; i_num_passes = (NB_IDX+1)'(n_req); i_settle = NB_SETTLE'(settle);
    if (noise && $urandom_range(0, 1) == 1) begin
      i_tbl_wr = 1; i_tbl_addr = NB_IDX'($urandom_range(0, 7)); i_tbl_data = NB_DATA'($urandom);
      tbl[i_tbl_addr] = i_tbl_data;
    end
    s = cyc;
    for (int k = 0; k < p; k++) begin
      g[k] = (k == 0) ? s + 2 : d[k-1] + settle + 3;
      d[k] = g[k] + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12)));
    end
    done_c  = (p == 0) ? s + 1 : d[p-1] + settle + 2;
    abort_c = (abort_pass >= 0 && abort_pass < p) ? d[abort_pass] : -1;
    lim     = (abort_c >= 0) ? abort_c + 1 : done_c;
    tick();
    i_start = 0; i_tbl_wr = 0;
    while (cyc <= lim + 2) begin
      exp_go = 0; in_run = 0; hit_done = 0;
      for (int k = 0; k < p; k++) begin
        if (g[k] == cyc && cyc < lim) exp_go = 1;
        if (cyc > g[k] && cyc <= d[k]) in_run = 1;
        if (d[k] == cyc && cyc < lim) hit_done = 1;
        if (cyc >= g[k] && cyc <= d[k] && cyc < lim) begin
          checks++;
          if (o_pass_idx !== NB_IDX'(k)) begin
            failures++; $display("FAIL pass_idx cyc=%0d got=%0d exp=%0d", cyc, o_pass_idx, k);
          end
          checks++;
          if (o_cfg_umbral !== tbl[k]) begin
            failures++; $display("FAIL umbral cyc=%0d pass=%0d got=%0d exp=%0d", cyc, k, o_cfg_umbral, tbl[k]);
          end
        end
      end
      exp_busy  = (cyc < lim);
      exp_done  = (abort_c < 0 && cyc == done_c);
      exp_abort = (abort_c >= 0 && cyc == abort_c + 1);
      checks++;
      if (o_cfg_go !== exp_go) begin
        failures++; $display("FAIL go cyc=%0d got=%0b exp=%0b", cyc, o_cfg_go, exp_go);
      end
      checks++;
      if (o_done !== exp_done) begin
        failures++; $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, o_done, exp_done);
      end
      checks++;
      if (o_busy !== exp_busy) begin
        failures++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, exp_busy);
      end
      checks++;
      if (o_cfg_abort !== exp_abort) begin
        failures++; $display("FAIL cfg_abort cyc=%0d got=%0b exp=%0b", cyc, o_cfg_abort, exp_abort);
      end
      checks++;
      if (o_error !== 1'b0) begin
        failures++; $display("FAIL error_clear cyc=%0d got=%0b exp=0", cyc, o_error);
      end
      if (abort_c >= 0 && cyc == lim) begin
        checks++;
        if (o_pass_idx !== NB_IDX'(abort_pass)) begin
          failures++; $display("FAIL abort_idx got=%0d exp=%0d", o_pass_idx, abort_pass);
        end
      end
      // Drive the next cycle: model FSM done, abort, and ignored noise while busy.
      i_cfg_done = hit_done || (noise && cyc < lim && !in_run && $urandom_range(0, 2) == 0);
      i_abort    = (cyc == abort_c);
      i_start    = noise && cyc < lim && $urandom_range(0, 3) == 0;
      i_num_passes = (NB_IDX+1)'($urandom_range(1, 8));
      i_chip_write_ready = 1'($urandom_range(0, 1));
      if (noise && p > 0 && cyc == s + 3) begin
        i_tbl_wr = 1; i_tbl_addr = '0; i_tbl_data = NB_DATA'(999);
      end else begin
        i_tbl_wr = noise && cyc < lim && $urandom_range(0, 3) == 0;
        i_tbl_addr = NB_IDX'($urandom_range(0, 7)); i_tbl_data = NB_DATA'($urandom);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) tick();
    checks++;
    if ({o_cfg_go, o_cfg_abort, o_busy, o_done, o_error, o_pass_idx, o_cfg_umbral} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0",
        {o_cfg_go, o_cfg_abort, o_busy, o_done, o_error, o_pass_idx, o_cfg_umbral});
    end
    rst = 0;
    tick();
    checks++;
    if ({o_cfg_go, o_cfg_abort, o_busy, o_done, o_error} !== 5'b0) begin
      failures++; $display("FAIL post_reset got=%0b exp=0", {o_cfg_go, o_cfg_abort, o_busy, o_done, o_error});
    end
    for (int i = 0; i < int'(N_ENTRIES); i++) tbl[i] = '0;
  endtask

  task automatic test_three_passes();
    write_tbl(0, 100); write_tbl(1, 200); write_tbl(2, 300);
    run_seq(3, 0, -1, 0, 10);
  endtask

  task automatic test_zero_passes();
    run_seq(0, 0, -1, 0, 0);
  endtask

  task automatic test_settle();
    run_seq(2, 5, -1, 0, 10);
  endtask

  task automatic test_watchdog();
    int s, g, j, e;
    i_start = 1; i_num_passes = 4'd2; i_settle = '0;
    s = cyc; g = s + 2; j = g + int'($urandom_range(1, 8)); e = j + int'(WDT) + 1;
    tick();
    i_start = 0;
    while (cyc <= e + 4) begin
      checks++;
      if (o_cfg_go !== (cyc == g)) begin
        failures++; $display("FAIL wdt_go cyc=%0d got=%0b exp=%0b", cyc, o_cfg_go, cyc == g);
      end
      checks++;
      if (o_busy !== (cyc < e)) begin
        failures++; $display("FAIL wdt_busy cyc=%0d got=%0b exp=%0b", cyc, o_busy, cyc < e);
      end
      checks++;
      if (o_cfg_abort !== (cyc == e)) begin
        failures++; $display("FAIL wdt_abort cyc=%0d got=%0b exp=%0b", cyc, o_cfg_abort, cyc == e);
      end
      checks++;
      if (o_error !== (cyc >= e)) begin
        failures++; $display("FAIL wdt_error cyc=%0d got=%0b exp=%0b", cyc, o_error, cyc >= e);
      end
      i_chip_write_ready = (cyc == j);
      tick();
    end
    i_chip_write_ready = 0;
    i_start = 1; i_num_passes = '0;
    tick();
    i_start = 0;
    checks++;
    if ({o_error, o_done, o_busy} !== 3'b010) begin
      failures++; $display("FAIL restart_clears_error got=%0b exp=010", {o_error, o_done, o_busy});
    end
    tick();
  endtask

  task automatic test_abort_with_done();
    for (int i = 0; i < 3; i++) write_tbl(i, int'($urandom_range(1, 4095)));
    run_seq(3, 2, 1, 0, 0);
    run_seq(2, 0, 0, 0, 0);
  endtask

  task automatic test_busy_write();
    write_tbl(0, 1234);
    run_seq(1, 0, -1, 1, 5);
    run_seq(2, 1, -1, 0, 0);
  endtask

  task automatic test_error_abort();
    int s, e;
    i_start = 1; i_num_passes = 4'd1;
    s = cyc; e = s + 2 + int'(WDT) + 1;
    tick();
    i_start = 0;
    while (cyc < e + 2) tick();
    i_abort = 1;
    tick();
    i_abort = 0;
    repeat (2) begin
      checks++;
      if ({o_error, o_busy, o_cfg_abort, o_done} !== 4'b1000) begin
        failures++; $display("FAIL error_abort got=%0b exp=1000", {o_error, o_busy, o_cfg_abort, o_done});
      end
      tick();
    end
    run_seq(1, 0, -1, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    int s, d0, g1;
    write_tbl(0, int'($urandom_range(1, 4095)));
    write_tbl(1, int'($urandom_range(1, 4095)));
    i_start = 1; i_num_passes = 4'd3; i_settle = '0;
    s = cyc; d0 = s + 2 + 10; g1 = d0 + 3;
    tick();
    i_start = 0;
    while (cyc < g1 + 3) begin
      i_cfg_done = (cyc == d0);
      tick();
    end
    i_cfg_done = 0;
    checks++;
    if ({o_busy, o_pass_idx, o_cfg_umbral} !== {1'b1, NB_IDX'(1), tbl[1]}) begin
      failures++; $display("FAIL pre_reset got=%0h exp=%0h", {o_busy, o_pass_idx, o_cfg_umbral},
        {1'b1, NB_IDX'(1), tbl[1]});
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({o_cfg_go, o_cfg_abort, o_busy, o_done, o_error, o_pass_idx, o_cfg_umbral} !== '0) begin
      failures++; $display("FAIL async_reset got=%0h exp=0",
        {o_cfg_go, o_cfg_abort, o_busy, o_done, o_error, o_pass_idx, o_cfg_umbral});
    end
    tick();
    rst = 0;
    for (int i = 0; i < int'(N_ENTRIES); i++) tbl[i] = '0;
    tick();
    run_seq(2, 0, -1, 0, 3);
  endtask

  task automatic test_random();
    int n, st, ab;
    for (int it = 0; it < 10; it++) begin
      repeat (3) write_tbl(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
      n  = int'($urandom_range(0, 12));
      st = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 2) == 0 && n > 0) ? int'($urandom_range(0, (n > 8 ? 8 : n) - 1)) : -1;
      run_seq(n, st, ab, 1, 0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_three_passes();
    test_zero_passes();
    test_settle();
    test_watchdog();
    test_abort_with_done();
    test_busy_write();
    test_error_abort();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
